trap_sequencer: RTL and testbench

Sequences trap entry and MRET return around the CSR/exception unit of the RV32IMA+Zicsr core. It accepts one exception or MRET report from the commit stage, then flushes and drains the pipeline. It presents a single one-hot exception flag to the CSR unit for exactly one cycle, then redirects fetch to the handler or EPC address through a valid/ready handshake. While a sequence is in flight it stalls CSR commands, so CSR writes never race trap-state updates.

---
 rtl/trap_sequencer.sv | 196 +++++++++++++++++++
 tb/tb_trap_sequencer.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/trap_sequencer.sv
// Trap entry / MRET return sequencer: accepts one commit-stage report, drains the
// pipeline, pulses the CSR unit for one cycle, then redirects fetch via valid/ready.
module trap_sequencer #(
   parameter int XLEN          = 32,
   parameter int DRAIN_TIMEOUT = 16
) (
   input  logic            clk,
   input  logic            nrst,
   input  logic            excp_valid,
   input  logic [5:0]      excp_flags,
   input  logic [XLEN-1:0] excp_pc,
   input  logic [XLEN-1:0] excp_tval,
   input  logic            mret_valid,
   output logic            excp_ready,
   output logic            flush,
   input  logic            drain_done,
   output logic [5:0]      trap_flags,
   output logic [XLEN-1:0] trap_pc,
   output logic [XLEN-1:0] trap_tval,
   output logic [4:0]      trap_cause,
   output logic            mret_commit,
   input  logic [XLEN-1:0] handler_addr,
   input  logic [XLEN-1:0] epc_value,
   output logic            redirect_valid,
   output logic [XLEN-1:0] redirect_pc,
   input  logic            redirect_ready,
   output logic            csr_stall,
   output logic            drain_timeout
);

   localparam int CNT_W = (DRAIN_TIMEOUT > 2) ? $clog2(DRAIN_TIMEOUT) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DRAIN_TIMEOUT - 1);

   typedef enum logic [1:0] {
      IDLE,
      DRAIN,
      COMMIT,
      REDIRECT
   } state_e;

   state_e            state_q;
   logic [CNT_W-1:0]  cnt_q;
   logic              is_mret_q;
   logic [5:0]        flag_lat_q;
   logic [4:0]        cause_lat_q;
   logic [XLEN-1:0]   pc_lat_q;
   logic [XLEN-1:0]   tval_lat_q;

   logic              flush_q;
   logic [5:0]        trap_flags_q;
   logic [XLEN-1:0]   trap_pc_q;
   logic [XLEN-1:0]   trap_tval_q;
   logic [4:0]        trap_cause_q;
   logic              mret_commit_q;
   logic              redirect_valid_q;
   logic [XLEN-1:0]   redirect_pc_q;
   logic              csr_stall_q;
   logic              drain_timeout_q;

   logic [5:0]        sel_flag_d;
   logic [4:0]        sel_cause_d;

   // Flag bits: [5] store/amo misalign, [4] load misalign, [3] ebreak, [2] ecall,
   // [1] illegal instruction, [0] instruction address misalign.
   always_comb begin
      sel_flag_d  = 6'b000000;
      sel_cause_d = 5'd0;
      if (excp_flags[0]) begin
         sel_flag_d  = 6'b000001;
         sel_cause_d = 5'd0;
      end else if (excp_flags[1]) begin
         sel_flag_d  = 6'b000010;
         sel_cause_d = 5'd2;
      end else if (excp_flags[3]) begin
         sel_flag_d  = 6'b001000;
         sel_cause_d = 5'd3;
      end else if (excp_flags[2]) begin
         sel_flag_d  = 6'b000100;
         sel_cause_d = 5'd11;
      end else if (excp_flags[4]) begin
         sel_flag_d  = 6'b010000;
         sel_cause_d = 5'd4;
      end else if (excp_flags[5]) begin
         sel_flag_d  = 6'b100000;
         sel_cause_d = 5'd6;
      end
   end

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         state_q          <= IDLE;
         cnt_q            <= '0;
         is_mret_q        <= 1'b0;
         flag_lat_q       <= '0;
         cause_lat_q      <= '0;
         pc_lat_q         <= '0;
         tval_lat_q       <= '0;
         flush_q          <= 1'b0;
         trap_flags_q     <= '0;
         trap_pc_q        <= '0;
         trap_tval_q      <= '0;
         trap_cause_q     <= '0;
         mret_commit_q    <= 1'b0;
         redirect_valid_q <= 1'b0;
         redirect_pc_q    <= '0;
         csr_stall_q      <= 1'b0;
         drain_timeout_q  <= 1'b0;
      end else begin
         // CSR-facing pulses only live for the single COMMIT cycle.
         trap_flags_q    <= '0;
         trap_pc_q       <= '0;
         trap_tval_q     <= '0;
         trap_cause_q    <= '0;
         mret_commit_q   <= 1'b0;
         drain_timeout_q <= 1'b0;

         case (state_q)
            IDLE: begin
               if (excp_valid && (excp_flags != 6'b000000)) begin
                  state_q     <= DRAIN;
                  cnt_q       <= '0;
                  is_mret_q   <= 1'b0;
                  flag_lat_q  <= sel_flag_d;
                  cause_lat_q <= sel_cause_d;
                  pc_lat_q    <= excp_pc;
                  tval_lat_q  <= excp_tval;
                  flush_q     <= 1'b1;
                  csr_stall_q <= 1'b1;
               end else if (mret_valid) begin
                  state_q     <= DRAIN;
                  cnt_q       <= '0;
                  is_mret_q   <= 1'b1;
                  flag_lat_q  <= '0;
                  cause_lat_q <= '0;
                  pc_lat_q    <= '0;
                  tval_lat_q  <= '0;
                  flush_q     <= 1'b1;
                  csr_stall_q <= 1'b1;
               end
            end

            DRAIN: begin
               cnt_q <= cnt_q + CNT_W'(1);
               if (drain_done || (cnt_q == CNT_LAST)) begin
                  state_q         <= COMMIT;
                  flush_q         <= 1'b0;
                  drain_timeout_q <= ~drain_done;
                  if (is_mret_q) begin
                     mret_commit_q <= 1'b1;
                  end else begin
                     trap_flags_q <= flag_lat_q;
                     trap_pc_q    <= pc_lat_q;
                     trap_tval_q  <= tval_lat_q;
                     trap_cause_q <= cause_lat_q;
                  end
               end
            end

            // Target is sampled while the CSR update is still in flight.
            COMMIT: begin
               state_q          <= REDIRECT;
               redirect_valid_q <= 1'b1;
               redirect_pc_q    <= is_mret_q ? epc_value : handler_addr;
            end

            REDIRECT: begin
               if (redirect_ready) begin
                  state_q          <= IDLE;
                  redirect_valid_q <= 1'b0;
                  csr_stall_q      <= 1'b0;
               end
            end

            default: begin
               state_q          <= IDLE;
               flush_q          <= 1'b0;
               redirect_valid_q <= 1'b0;
               csr_stall_q      <= 1'b0;
            end
         endcase
      end
   end

   assign excp_ready     = (state_q == IDLE);
   assign flush          = flush_q;
   assign trap_flags     = trap_flags_q;
   assign trap_pc        = trap_pc_q;
   assign trap_tval      = trap_tval_q;
   assign trap_cause     = trap_cause_q;
   assign mret_commit    = mret_commit_q;
   assign redirect_valid = redirect_valid_q;
   assign redirect_pc    = redirect_pc_q;
   assign csr_stall      = csr_stall_q;
   assign drain_timeout  = drain_timeout_q;

endmodule

// File: tb/tb_trap_sequencer.sv
// Directed bench for trap_sequencer: a vector table of single reports plus
// hand-written sequences for timeout, backpressure, back-to-back and reset.
module tb_trap_sequencer;

   localparam int XLEN = 32;

   logic            clk;
   logic            nrst;
   logic            excp_valid;
   logic [5:0]      excp_flags;
   logic [XLEN-1:0] excp_pc;
   logic [XLEN-1:0] excp_tval;
   logic            mret_valid;
   logic            excp_ready;
   logic            flush;
   logic            drain_done;
   logic [5:0]      trap_flags;
   logic [XLEN-1:0] trap_pc;
   logic [XLEN-1:0] trap_tval;
   logic [4:0]      trap_cause;
   logic            mret_commit;
   logic [XLEN-1:0] handler_addr;
   logic [XLEN-1:0] epc_value;
   logic            redirect_valid;
   logic [XLEN-1:0] redirect_pc;
   logic            redirect_ready;
   logic            csr_stall;
   logic            drain_timeout;

   int checks = 0;
   int errors = 0;

   trap_sequencer #(.XLEN(XLEN), .DRAIN_TIMEOUT(16)) dut (
      .clk           (clk),
      .nrst          (nrst),
      .excp_valid    (excp_valid),
      .excp_flags    (excp_flags),
      .excp_pc       (excp_pc),
      .excp_tval     (excp_tval),
      .mret_valid    (mret_valid),
      .excp_ready    (excp_ready),
      .flush         (flush),
      .drain_done    (drain_done),
      .trap_flags    (trap_flags),
      .trap_pc       (trap_pc),
      .trap_tval     (trap_tval),
      .trap_cause    (trap_cause),
      .mret_commit   (mret_commit),
      .handler_addr  (handler_addr),
      .epc_value     (epc_value),
      .redirect_valid(redirect_valid),
      .redirect_pc   (redirect_pc),
      .redirect_ready(redirect_ready),
      .csr_stall     (csr_stall),
      .drain_timeout (drain_timeout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        excpValid;
      logic [5:0]  flags;
      logic        mretValid;
      logic [31:0] pc;
      logic [31:0] tval;
      logic [31:0] handler;
      logic [31:0] epc;
      logic [5:0]  expFlags;
      logic [4:0]  expCause;
      logic        expMret;
      logic [31:0] expRedirect;
   } vector_t;

   vector_t vecs[10];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // One complete sequence with drain_done and redirect_ready high at once.
   task automatic applyStimulus(input vector_t v);
      excp_valid     = v.excpValid;
      excp_flags     = v.flags;
      mret_valid     = v.mretValid;
      excp_pc        = v.pc;
      excp_tval      = v.tval;
      handler_addr   = 32'hBAD0_0000;
      epc_value      = 32'hBAD1_0000;
      drain_done     = 1'b0;
      redirect_ready = 1'b1;
      checkOutput("idle_ready", 32'(excp_ready), 32'd1);
      tick();
      checkOutput("c1_flush", 32'(flush), 32'd1);
      checkOutput("c1_ready", 32'(excp_ready), 32'd0);
      checkOutput("c1_stall", 32'(csr_stall), 32'd1);
      checkOutput("c1_flags", 32'(trap_flags), 32'd0);
      excp_valid = 1'b0;
      mret_valid = 1'b0;
      excp_pc    = 32'hFFFF_0000;
      excp_tval  = 32'hFFFF_1111;
      drain_done = 1'b1;
      tick();
      drain_done = 1'b0;
      checkOutput("c2_trap_flags", 32'(trap_flags), 32'(v.expFlags));
      checkOutput("c2_trap_cause", 32'(trap_cause), 32'(v.expCause));
      checkOutput("c2_trap_pc", trap_pc, v.expMret ? 32'd0 : v.pc);
      checkOutput("c2_trap_tval", trap_tval, v.expMret ? 32'd0 : v.tval);
      checkOutput("c2_mret_commit", 32'(mret_commit), 32'(v.expMret));
      checkOutput("c2_flush", 32'(flush), 32'd0);
      checkOutput("c2_timeout", 32'(drain_timeout), 32'd0);
      checkOutput("c2_rvalid", 32'(redirect_valid), 32'd0);
      handler_addr = v.handler;
      epc_value    = v.epc;
      tick();
      checkOutput("c3_rvalid", 32'(redirect_valid), 32'd1);
      checkOutput("c3_redirect_pc", redirect_pc, v.expRedirect);
      checkOutput("c3_trap_flags", 32'(trap_flags), 32'd0);
      checkOutput("c3_mret_commit", 32'(mret_commit), 32'd0);
      checkOutput("c3_stall", 32'(csr_stall), 32'd1);
      handler_addr = 32'hBAD2_0000;
      epc_value    = 32'hBAD3_0000;
      tick();
      checkOutput("c4_ready", 32'(excp_ready), 32'd1);
      checkOutput("c4_rvalid", 32'(redirect_valid), 32'd0);
      checkOutput("c4_stall", 32'(csr_stall), 32'd0);
   endtask

   initial begin
      int flushCount;
      logic sawPulse;

      //            ev  flags      mret pc            tval          handler       epc           expFlags   cause  mret expRedirect
      vecs[0] = '{1'b1, 6'b000100, 1'b0, 32'h0000_0100, 32'h0,        32'h0000_0800, 32'h0,        6'b000100, 5'd11, 1'b0, 32'h0000_0800};
      vecs[1] = '{1'b1, 6'b110010, 1'b0, 32'h0000_0200, 32'h0000_DEAD, 32'h0000_0900, 32'h0,        6'b000010, 5'd2,  1'b0, 32'h0000_0900};
      vecs[2] = '{1'b1, 6'b001000, 1'b1, 32'h0000_0300, 32'h0,        32'h0000_0A00, 32'h0000_7777, 6'b001000, 5'd3,  1'b0, 32'h0000_0A00};
      vecs[3] = '{1'b0, 6'b000000, 1'b1, 32'h0,        32'h0,        32'h0000_0B00, 32'h0000_1234, 6'b000000, 5'd0,  1'b1, 32'h0000_1234};
      vecs[4] = '{1'b1, 6'b111111, 1'b0, 32'h0000_0400, 32'h0000_0401, 32'h0000_0C00, 32'h0,        6'b000001, 5'd0,  1'b0, 32'h0000_0C00};
      vecs[5] = '{1'b1, 6'b111100, 1'b0, 32'h0000_0500, 32'h0,        32'h0000_0D00, 32'h0,        6'b001000, 5'd3,  1'b0, 32'h0000_0D00};
      vecs[6] = '{1'b1, 6'b110100, 1'b0, 32'h0000_0600, 32'h0,        32'h0000_0E00, 32'h0,        6'b000100, 5'd11, 1'b0, 32'h0000_0E00};
      vecs[7] = '{1'b1, 6'b110000, 1'b0, 32'h0000_0700, 32'h0000_0070, 32'h0000_0F00, 32'h0,        6'b010000, 5'd4,  1'b0, 32'h0000_0F00};
      vecs[8] = '{1'b1, 6'b100000, 1'b0, 32'h0000_0800, 32'h0000_0081, 32'h0000_1000, 32'h0,        6'b100000, 5'd6,  1'b0, 32'h0000_1000};
      vecs[9] = '{1'b1, 6'b000000, 1'b1, 32'h0000_0900, 32'h0,        32'h0000_1100, 32'h0000_55AA, 6'b000000, 5'd0,  1'b1, 32'h0000_55AA};

      nrst           = 1'b0;
      excp_valid     = 1'b0;
      excp_flags     = '0;
      excp_pc        = '0;
      excp_tval      = '0;
      mret_valid     = 1'b0;
      drain_done     = 1'b0;
      handler_addr   = '0;
      epc_value      = '0;
      redirect_ready = 1'b0;

      tick();
      checkOutput("rst_ready", 32'(excp_ready), 32'd1);
      checkOutput("rst_flush", 32'(flush), 32'd0);
      checkOutput("rst_stall", 32'(csr_stall), 32'd0);
      checkOutput("rst_rvalid", 32'(redirect_valid), 32'd0);
      checkOutput("rst_rpc", redirect_pc, 32'd0);
      checkOutput("rst_flags", 32'(trap_flags), 32'd0);
      tick();
      nrst = 1'b1;
      tick();

      for (int i = 0; i < 10; i++) begin
         applyStimulus(vecs[i]);
      end

      // Zero flags without MRET must be ignored.
      excp_valid = 1'b1;
      excp_flags = 6'b000000;
      tick();
      excp_valid = 1'b0;
      checkOutput("zero_flags_ready", 32'(excp_ready), 32'd1);
      checkOutput("zero_flags_flush", 32'(flush), 32'd0);

      // New report presented in cycle 4 is accepted.
      applyStimulus(vecs[0]);
      excp_valid = 1'b1;
      excp_flags = 6'b100000;
      excp_pc    = 32'h0000_0C0C;
      tick();
      checkOutput("b2b_flush", 32'(flush), 32'd1);
      excp_valid = 1'b0;
      drain_done = 1'b1;
      tick();
      drain_done = 1'b0;
      checkOutput("b2b_cause", 32'(trap_cause), 32'd6);
      checkOutput("b2b_pc", trap_pc, 32'h0000_0C0C);
      tick();
      tick();
      checkOutput("b2b_ready", 32'(excp_ready), 32'd1);

      // Drain timeout: drain_done stays low.
      excp_valid = 1'b1;
      excp_flags = 6'b000100;
      excp_pc    = 32'h0000_0100;
      handler_addr = 32'h0000_2000;
      redirect_ready = 1'b1;
      tick();
      excp_valid = 1'b0;
      flushCount = 0;
      while (flush && flushCount < 40) begin
         flushCount++;
         tick();
      end
      checkOutput("to_flush_cycles", 32'(flushCount), 32'd16);
      checkOutput("to_drain_timeout", 32'(drain_timeout), 32'd1);
      checkOutput("to_trap_flags", 32'(trap_flags), 32'b000100);
      drain_done = 1'b1;
      tick();
      drain_done = 1'b0;
      checkOutput("to_timeout_clear", 32'(drain_timeout), 32'd0);
      checkOutput("to_rvalid", 32'(redirect_valid), 32'd1);
      checkOutput("to_rpc", redirect_pc, 32'h0000_2000);
      tick();
      checkOutput("to_ready", 32'(excp_ready), 32'd1);

      // Redirect backpressure with an ignored report during REDIRECT.
      excp_valid     = 1'b1;
      excp_flags     = 6'b000010;
      excp_pc        = 32'h0000_0400;
      redirect_ready = 1'b0;
      tick();
      excp_valid = 1'b0;
      drain_done = 1'b1;
      tick();
      drain_done   = 1'b0;
      handler_addr = 32'h0000_4444;
      tick();
      for (int i = 0; i < 5; i++) begin
         checkOutput("bp_rvalid", 32'(redirect_valid), 32'd1);
         checkOutput("bp_rpc", redirect_pc, 32'h0000_4444);
         checkOutput("bp_stall", 32'(csr_stall), 32'd1);
         checkOutput("bp_ready", 32'(excp_ready), 32'd0);
         handler_addr = 32'h0000_5000 + 32'(i);
         excp_valid   = (i == 2);
         excp_flags   = 6'b000001;
         tick();
      end
      excp_valid     = 1'b0;
      redirect_ready = 1'b1;
      checkOutput("bp_last_rvalid", 32'(redirect_valid), 32'd1);
      checkOutput("bp_last_rpc", redirect_pc, 32'h0000_4444);
      tick();
      checkOutput("bp_idle_ready", 32'(excp_ready), 32'd1);
      checkOutput("bp_idle_rvalid", 32'(redirect_valid), 32'd0);
      checkOutput("bp_idle_stall", 32'(csr_stall), 32'd0);
      sawPulse = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         if (flush || (trap_flags != 6'b0)) sawPulse = 1'b1;
      end
      checkOutput("bp_pulse_ignored", 32'(sawPulse), 32'd0);

      // Reset during DRAIN of an MRET.
      mret_valid = 1'b1;
      epc_value  = 32'h0000_9999;
      tick();
      mret_valid = 1'b0;
      checkOutput("rd_in_drain", 32'(flush), 32'd1);
      nrst = 1'b0;
      #1;
      checkOutput("rd_ready", 32'(excp_ready), 32'd1);
      checkOutput("rd_flush", 32'(flush), 32'd0);
      checkOutput("rd_stall", 32'(csr_stall), 32'd0);
      checkOutput("rd_rvalid", 32'(redirect_valid), 32'd0);
      checkOutput("rd_rpc", redirect_pc, 32'd0);
      checkOutput("rd_mret", 32'(mret_commit), 32'd0);
      checkOutput("rd_timeout", 32'(drain_timeout), 32'd0);
      tick();
      nrst       = 1'b1;
      drain_done = 1'b1;
      sawPulse   = 1'b0;
      for (int i = 0; i < 6; i++) begin
         tick();
         if (mret_commit || (trap_flags != 6'b0) || flush || redirect_valid) sawPulse = 1'b1;
      end
      drain_done = 1'b0;
      checkOutput("rd_no_commit", 32'(sawPulse), 32'd0);
      checkOutput("rd_final_ready", 32'(excp_ready), 32'd1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
